// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-coded switch capture path.
package gray_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } cap_state_t;

  // Default bus width; the helpers work on a wider container so any WIDTH up
  // to GRAY_MAX_W can be handled by zero-extending the operand.
  localparam int unsigned GRAY_W     = 4;
  localparam int unsigned GRAY_MAX_W = 32;

  // Each binary bit is the XOR of all Gray bits at or above its position.
  // Zero-extended upper bits contribute nothing, so this stays correct for
  // any narrower width.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int unsigned k = 1; k < GRAY_MAX_W; k++) begin
      b = b ^ (g >> k);
    end
    return b;
  endfunction

  // True when more than one bit is set (clearing the lowest set bit leaves
  // something behind).
  function automatic logic popcount_gt1(input logic [GRAY_MAX_W-1:0] x);
    return (x & (x - GRAY_MAX_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_input_capture_sync.sv
// Multi-stage flop synchronizer for a bus that is asynchronous to i_clk.
module sync_ff #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gray_input_capture.sv
// Gray-coded switch capture: synchronize, debounce, convert to binary and
// publish each newly stable code with a one-cycle code_valid strobe.
// Optional: define GRAY_STEP_CHECK_EN to add step_error, which flags commits
// that were not a single-bit Gray step.
module gray_input_capture
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH           = GRAY_W,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] binary_code,
  output logic             code_valid,
  output logic             stable
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             step_error
`endif
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  cap_state_t       r_state;
  cap_state_t       w_state_nxt;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] w_cand_nxt;
  logic [WIDTH-1:0] r_cg;
  logic [WIDTH-1:0] w_cg_nxt;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_valid;
  logic             w_commit;

  sync_ff #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (gray_in),
    .o_q   (w_sync)
  );

  // Debounce FSM: next state, candidate, counter and commit decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_cg_nxt    = r_cg;
    w_bin_nxt   = r_bin;
    w_commit    = 1'b0;
    case (r_state)
      STABLE: begin
        w_cnt_nxt = '0;
        if (w_sync != r_cg) begin
          w_cand_nxt  = w_sync;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (w_sync == r_cg) begin
          // Input returned to the committed code: glitch, drop it silently.
          w_cnt_nxt   = '0;
          w_state_nxt = STABLE;
        end else if (w_sync != r_cand) begin
          // Bounce to yet another code restarts the stability count.
          w_cand_nxt = w_sync;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_commit    = 1'b1;
          w_cg_nxt    = r_cand;
          w_bin_nxt   = WIDTH'(gray2bin(GRAY_MAX_W'(r_cand)));
          w_cnt_nxt   = '0;
          w_state_nxt = STABLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE;
      end
    endcase
  end

  // FSM state and debounce datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STABLE;
      r_cand  <= '0;
      r_cg    <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cg    <= w_cg_nxt;
      r_bin   <= w_bin_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_commit;
    end
  end

  assign binary_code = r_bin;
  assign code_valid  = r_valid;
  assign stable      = (r_state == STABLE);

`ifdef GRAY_STEP_CHECK_EN
  logic r_step_err;

  // Flag a commit whose transition changed more than one Gray bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_err <= 1'b0;
    end else begin
      r_step_err <= w_commit & popcount_gt1(GRAY_MAX_W'(r_cand ^ r_cg));
    end
  end

  assign step_error = r_step_err;
`endif

endmodule

// File: tb/tb_gray_input_capture.sv
// Bench for gray_input_capture (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A reference model pushes expected commits into a scoreboard queue; a
// negedge monitor pops and compares whenever code_valid is seen.
`timescale 1ns/1ps
module tb_gray_input_capture;

  localparam int SS = 2;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = 4'h0;
  logic [3:0] binary_code;
  logic       code_valid;
  logic       stable;
`ifdef GRAY_STEP_CHECK_EN
  logic       step_error;
`endif

  gray_input_capture #(
    .WIDTH           (4),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gray_in     (gray_in),
    .binary_code (binary_code),
    .code_valid  (code_valid),
    .stable      (stable)
`ifdef GRAY_STEP_CHECK_EN
    ,
    .step_error  (step_error)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bin;
    logic       step;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks       = 0;
  int   n_fail         = 0;
  int   cyc            = 0;
  int   pulses         = 0;
  int   last_pulse_cyc = -1;
  logic last_step      = 1'b0;
  logic prev_valid     = 1'b0;
  logic exp_stable     = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Binary value whose Gray encoding (b ^ b>>1) equals g, found by search.
  function automatic logic [3:0] ref_bin(input logic [3:0] g);
    logic [3:0] c;
    for (int v = 0; v < 16; v++) begin
      c = 4'(v);
      if ((c ^ (c >> 1)) == g) return c;
    end
    return 4'h0;
  endfunction

  // Reference model: the FSM sees gray_in delayed by SS edges; a new code
  // commits once it has been seen unchanged for DB+1 consecutive edges.
  initial begin : model
    logic [3:0] pipe[$];
    logic [3:0] s;
    logic [3:0] last_s;
    logic [3:0] m_cg;
    int         run;
    pipe = {};
    for (int i = 0; i < SS; i++) pipe.push_back(4'h0);
    last_s = 4'h0;
    m_cg   = 4'h0;
    run    = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pipe = {};
        for (int i = 0; i < SS; i++) pipe.push_back(4'h0);
        last_s     = 4'h0;
        m_cg       = 4'h0;
        run        = 0;
        exp_stable = 1'b1;
      end else begin
        pipe.push_back(gray_in);
        s = pipe.pop_front();
        if (s == last_s) begin
          if (run < DB + 2) run++;
        end else begin
          run = 1;
        end
        last_s = s;
        if (s != m_cg && run == DB + 1) begin
          exp_q.push_back('{ref_bin(s), ($countones(s ^ m_cg) > 1), cyc});
          m_cg = s;
        end
        exp_stable = (s == m_cg);
      end
    end
  end

  // Asynchronous reset forces the idle state immediately.
  initial begin : rst_watch
    forever begin
      @(posedge rst);
      exp_stable = 1'b1;
    end
  end

  // Monitor: compare DUT outputs against the scoreboard on each falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      chk("stable", 32'(stable), 32'(exp_stable));
      if (code_valid) begin
        pulses++;
        last_pulse_cyc = cyc;
        chk("no_back_to_back_valid", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got code_valid=1 binary_code=%0d, required no pulse (t=%0t)",
                   binary_code, $time);
        end else begin
          e = exp_q.pop_front();
          chk("binary_code", 32'(binary_code), 32'(e.bin));
          chk("commit_cycle", 32'(cyc), 32'(e.cyc));
`ifdef GRAY_STEP_CHECK_EN
          chk("step_error", 32'(step_error), 32'(e.step));
          last_step = step_error;
`endif
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse: got code_valid=0, required pulse with binary_code=%0d at cycle %0d",
                 e.bin, e.cyc);
      end
      prev_valid = code_valid;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  logic [3:0] sweep [9];
  int         base;
  int         dc;
  logic [3:0] cur;
  logic [3:0] nxt;

  initial begin : stim
    sweep = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD};

    // Reset and idle
    rst     = 1'b1;
    gray_in = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_binary_code", 32'(binary_code), 32'd0);
    chk("reset_code_valid", 32'(code_valid), 32'd0);
    chk("reset_stable", 32'(stable), 32'd1);
    rst  = 1'b0;
    base = pulses;
    repeat (20) @(negedge clk);
    chk("idle_pulses", 32'(pulses - base), 32'd0);
    chk("idle_binary_code", 32'(binary_code), 32'd0);

    // Clean sweep
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      gray_in = sweep[i];
      dc      = cyc;
      base    = pulses;
      repeat (14) @(negedge clk);
      chk("sweep_pulses", 32'(pulses - base), 32'd1);
      chk("sweep_latency", 32'(last_pulse_cyc - dc), 32'd7);
      chk("sweep_binary_code", 32'(binary_code), 32'(i + 1));
    end

    // Bounce between 0110 and 0111, then settle on 0111
    base = pulses;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      gray_in = (k % 2 == 0) ? 4'h6 : 4'h7;
      @(negedge clk);
    end
    repeat (15) @(negedge clk);
    chk("bounce_pulses", 32'(pulses - base), 32'd1);
    chk("bounce_binary_code", 32'(binary_code), 32'd5);

    // Glitch rejection
    base = pulses;
    @(negedge clk);
    gray_in = 4'h5;
    repeat (2) @(negedge clk);
    @(negedge clk);
    gray_in = 4'h7;
    repeat (15) @(negedge clk);
    chk("glitch_pulses", 32'(pulses - base), 32'd0);
    chk("glitch_binary_code", 32'(binary_code), 32'd5);

    // Reset in the middle of SETTLE
    @(negedge clk);
    gray_in = 4'h1;
    repeat (14) @(negedge clk);
    chk("pre_reset_binary_code", 32'(binary_code), 32'd1);
    @(negedge clk);
    gray_in = 4'h3;
    repeat (3) @(negedge clk);
    #2;
    gray_in = 4'h0;
    rst     = 1'b1;
    #1;
    chk("async_reset_binary_code", 32'(binary_code), 32'd0);
    chk("async_reset_code_valid", 32'(code_valid), 32'd0);
    chk("async_reset_stable", 32'(stable), 32'd1);
    base = pulses;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_reset_pulses", 32'(pulses - base), 32'd0);
    chk("post_reset_binary_code", 32'(binary_code), 32'd0);

    // Two-bit step 0000->0011, then single-bit step 0011->0010
    @(negedge clk);
    gray_in = 4'h3;
    repeat (14) @(negedge clk);
    chk("double_step_binary_code", 32'(binary_code), 32'd2);
`ifdef GRAY_STEP_CHECK_EN
    chk("double_step_error", 32'(last_step), 32'd1);
`endif
    @(negedge clk);
    gray_in = 4'h2;
    repeat (14) @(negedge clk);
    chk("single_step_binary_code", 32'(binary_code), 32'd3);
`ifdef GRAY_STEP_CHECK_EN
    chk("single_step_error", 32'(last_step), 32'd0);
`endif

    // Randomized traffic: mixed single-bit steps and arbitrary jumps with
    // short holds that exercise bounce/glitch paths against the model.
    cur = gray_in;
    repeat (60) begin
      if ($urandom_range(0, 1) == 1) nxt = cur ^ (4'h1 << $urandom_range(0, 3));
      else                           nxt = 4'($urandom_range(0, 15));
      @(negedge clk);
      gray_in = nxt;
      repeat ($urandom_range(0, 8)) @(negedge clk);
      cur = nxt;
    end
    repeat (20) @(negedge clk);
    chk("random_final_binary_code", 32'(binary_code), 32'(ref_bin(cur)));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
